// File: rtl/aes_sbox_multi.sv
// AES SubBytes unit with NSBOX parallel forward/inverse SBoxes.
// Word mode runs 4/NSBOX passes; byte mode substitutes one byte in a single pass.
module aes_sbox_multi #(
  parameter int NSBOX = 1
) (
  input  logic        g_clk,
  input  logic        g_resetn,
  input  logic        valid,
  input  logic        dec,
  input  logic        bmode,
  input  logic [1:0]  bs,
  input  logic [31:0] rs1,
  output logic        busy,
  output logic        ready,
  output logic [31:0] rd
);

  localparam int NPASS = (NSBOX > 0) ? (4 / NSBOX) : 1;
  localparam logic [1:0] LAST_WORD = 2'(NPASS - 1);

  if (NSBOX != 1 && NSBOX != 2 && NSBOX != 4) begin : g_bad_nsbox
    $error("aes_sbox_multi: NSBOX must be 1, 2 or 4");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // GF(2^8) multiply modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int k = 0; k < 8; k++) begin
      p = b[k] ? (p ^ x) : p;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
    end
    return p;
  endfunction

  // x^254 is the multiplicative inverse, and conveniently maps 0 to 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] r;
    logic [7:0] sq;
    r  = 8'h01;
    sq = x;
    for (int k = 1; k < 8; k++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    logic [15:0] t;
    t = {b, b} << n;
    return t[15:8];
  endfunction

  function automatic logic [7:0] fwd_sbox(input logic [7:0] x);
    logic [7:0] b;
    b = gf_inv(x);
    return b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    return gf_inv(rotl(x, 1) ^ rotl(x, 3) ^ rotl(x, 6) ^ 8'h05);
  endfunction

  state_t      state_r;
  state_t      state_nxt_s;
  logic [1:0]  pass_r;
  logic [31:0] rs1_r;
  logic        dec_r;
  logic        bmode_r;
  logic [1:0]  bs_r;
  logic        busy_r;
  logic        ready_r;
  logic [31:0] rd_r;
  logic        accept_s;
  logic        last_s;
  logic [7:0]  sb_in_s   [NSBOX];
  logic [7:0]  sb_out_s  [NSBOX];
  logic [1:0]  sb_lane_s [NSBOX];

  // Accept decode and next-state logic.
  always_comb begin
    accept_s    = valid && (state_r == S_IDLE || state_r == S_DONE);
    last_s      = (pass_r == (bmode_r ? 2'd0 : LAST_WORD));
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE: if (accept_s) state_nxt_s = S_RUN;  else state_nxt_s = S_IDLE;
      S_RUN:  if (last_s)   state_nxt_s = S_DONE; else state_nxt_s = S_RUN;
      S_DONE: if (accept_s) state_nxt_s = S_RUN;  else state_nxt_s = S_IDLE;
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // State, registered status flags, operand capture and pass counter.
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      state_r <= S_IDLE;
      busy_r  <= 1'b0;
      ready_r <= 1'b0;
      pass_r  <= 2'd0;
      rs1_r   <= 32'h0000_0000;
      dec_r   <= 1'b0;
      bmode_r <= 1'b0;
      bs_r    <= 2'd0;
    end else begin
      state_r <= state_nxt_s;
      busy_r  <= (state_nxt_s == S_RUN);
      ready_r <= (state_nxt_s == S_DONE);
      if (accept_s) begin
        rs1_r   <= rs1;
        dec_r   <= dec;
        bmode_r <= bmode;
        bs_r    <= bs;
        pass_r  <= 2'd0;
      end else if (state_r == S_RUN && !last_s) begin
        pass_r <= pass_r + 2'd1;
      end
    end
  end

  // SBox inputs held at zero outside RUN and on idle instances in byte mode.
  always_comb begin
    for (int i = 0; i < NSBOX; i++) begin
      sb_lane_s[i] = 2'(int'(pass_r) * NSBOX + i);
      if (state_r != S_RUN) begin
        sb_in_s[i] = 8'h00;
      end else if (bmode_r) begin
        sb_in_s[i] = (i == 0) ? rs1_r[{bs_r, 3'b000} +: 8] : 8'h00;
      end else begin
        sb_in_s[i] = rs1_r[{sb_lane_s[i], 3'b000} +: 8];
      end
      sb_out_s[i] = dec_r ? inv_sbox(sb_in_s[i]) : fwd_sbox(sb_in_s[i]);
    end
  end

  // Result register: byte lanes written per pass, byte mode zero-extends.
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      rd_r <= 32'h0000_0000;
    end else if (state_r == S_RUN) begin
      if (bmode_r) begin
        rd_r <= {24'h00_0000, sb_out_s[0]};
      end else begin
        for (int i = 0; i < NSBOX; i++) begin
          rd_r[{sb_lane_s[i], 3'b000} +: 8] <= sb_out_s[i];
        end
      end
    end
  end

  assign busy  = busy_r;
  assign ready = ready_r;
  assign rd    = rd_r;

endmodule

// File: tb/tb_aes_sbox_multi.sv
// Directed bench for aes_sbox_multi: three instances (NSBOX = 1, 2, 4)
// share operand inputs; each has its own valid.
module tb_aes_sbox_multi;

  logic        g_clk = 1'b0;
  logic        g_resetn = 1'b0;
  logic        dec = 1'b0;
  logic        bmode = 1'b0;
  logic [1:0]  bs = 2'd0;
  logic [31:0] rs1 = 32'h0;
  logic        valid_a [3];
  logic        busy_a  [3];
  logic        ready_a [3];
  logic [31:0] rd_a    [3];
  int checks = 0;
  int errors = 0;

  always #5 g_clk = ~g_clk;

  aes_sbox_multi #(.NSBOX(1)) u_dut1 (
    .g_clk(g_clk), .g_resetn(g_resetn), .valid(valid_a[0]), .dec(dec), .bmode(bmode),
    .bs(bs), .rs1(rs1), .busy(busy_a[0]), .ready(ready_a[0]), .rd(rd_a[0]));
  aes_sbox_multi #(.NSBOX(2)) u_dut2 (
    .g_clk(g_clk), .g_resetn(g_resetn), .valid(valid_a[1]), .dec(dec), .bmode(bmode),
    .bs(bs), .rs1(rs1), .busy(busy_a[1]), .ready(ready_a[1]), .rd(rd_a[1]));
  aes_sbox_multi #(.NSBOX(4)) u_dut4 (
    .g_clk(g_clk), .g_resetn(g_resetn), .valid(valid_a[2]), .dec(dec), .bmode(bmode),
    .bs(bs), .rs1(rs1), .busy(busy_a[2]), .ready(ready_a[2]), .rd(rd_a[2]));

  task automatic tick();
    @(posedge g_clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (busy_a[d] !== 1'b0 || ready_a[d] !== 1'b0 || rd_a[d] !== 32'h0) begin
        errors++;
        $display("FAIL reset_hold dut%0d busy=%b ready=%b rd=%h, want 0 0 00000000",
                 d, busy_a[d], ready_a[d], rd_a[d]);
      end
    end
    #10 g_resetn = 1'b1;
    tick();
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (busy_a[d] !== 1'b0 || ready_a[d] !== 1'b0 || rd_a[d] !== 32'h0) begin
        errors++;
        $display("FAIL reset_release dut%0d busy=%b ready=%b rd=%h, want 0 0 00000000",
                 d, busy_a[d], ready_a[d], rd_a[d]);
      end
    end
  endtask

  task automatic test_word_fwd();
    dec = 1'b0; bmode = 1'b0; rs1 = 32'h0001_0203; valid_a[0] = 1'b1;
    tick();
    valid_a[0] = 1'b0;
    checks++;
    if (busy_a[0] !== 1'b1) begin
      errors++;
      $display("FAIL word_busy_accept got %b want 1", busy_a[0]);
    end
    for (int k = 1; k <= 5; k++) begin
      tick();
      checks++;
      if (ready_a[0] !== (k == 4)) begin
        errors++;
        $display("FAIL word_ready cycle %0d got %b want %b", k, ready_a[0], (k == 4));
      end
      checks++;
      if (busy_a[0] !== (k < 4)) begin
        errors++;
        $display("FAIL word_busy cycle %0d got %b want %b", k, busy_a[0], (k < 4));
      end
      if (k == 4) begin
        checks++;
        if (rd_a[0] !== 32'h637c_777b) begin
          errors++;
          $display("FAIL word_rd got %h want 637c777b", rd_a[0]);
        end
      end
    end
  endtask

  task automatic test_capture();
    dec = 1'b1; bmode = 1'b0; rs1 = 32'h637c_777b; valid_a[0] = 1'b1;
    tick();
    valid_a[0] = 1'b0;
    rs1 = 32'hffff_ffff; dec = 1'b0; bmode = 1'b1; bs = 2'd3;
    for (int k = 1; k <= 4; k++) tick();
    checks++;
    if (ready_a[0] !== 1'b1 || rd_a[0] !== 32'h0001_0203) begin
      errors++;
      $display("FAIL capture ready=%b rd=%h want 1 00010203", ready_a[0], rd_a[0]);
    end
    tick();
  endtask

  task automatic test_multi();
    dec = 1'b0; bmode = 1'b0; bs = 2'd0; rs1 = 32'h0001_0203;
    valid_a[1] = 1'b1; valid_a[2] = 1'b1;
    tick();
    valid_a[1] = 1'b0; valid_a[2] = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      tick();
      checks++;
      if (ready_a[1] !== (k == 2)) begin
        errors++;
        $display("FAIL nsbox2_ready cycle %0d got %b want %b", k, ready_a[1], (k == 2));
      end
      checks++;
      if (ready_a[2] !== (k == 1)) begin
        errors++;
        $display("FAIL nsbox4_ready cycle %0d got %b want %b", k, ready_a[2], (k == 1));
      end
      if (k == 2) begin
        checks++;
        if (rd_a[1] !== 32'h637c_777b) begin
          errors++;
          $display("FAIL nsbox2_rd got %h want 637c777b", rd_a[1]);
        end
      end
      if (k == 1) begin
        checks++;
        if (rd_a[2] !== 32'h637c_777b) begin
          errors++;
          $display("FAIL nsbox4_rd got %h want 637c777b", rd_a[2]);
        end
      end
    end
  endtask

  task automatic test_byte();
    dec = 1'b0; bmode = 1'b1; bs = 2'd2; rs1 = 32'h0053_0000;
    for (int d = 0; d < 3; d++) valid_a[d] = 1'b1;
    tick();
    for (int d = 0; d < 3; d++) valid_a[d] = 1'b0;
    rs1 = 32'hffff_ffff;
    tick();
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (ready_a[d] !== 1'b1 || rd_a[d] !== 32'h0000_00ed) begin
        errors++;
        $display("FAIL byte_fwd dut%0d ready=%b rd=%h want 1 000000ed", d, ready_a[d], rd_a[d]);
      end
    end
    dec = 1'b1; bs = 2'd0; rs1 = 32'h0000_00ed;
    for (int d = 0; d < 3; d++) valid_a[d] = 1'b1;
    tick();
    for (int d = 0; d < 3; d++) valid_a[d] = 1'b0;
    tick();
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (ready_a[d] !== 1'b1 || rd_a[d] !== 32'h0000_0053) begin
        errors++;
        $display("FAIL byte_inv dut%0d ready=%b rd=%h want 1 00000053", d, ready_a[d], rd_a[d]);
      end
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int strobes;
    logic [31:0] want;
    strobes = 0;
    dec = 1'b0; bmode = 1'b0; bs = 2'd0; rs1 = 32'h0001_0203; valid_a[0] = 1'b1;
    tick();
    rs1 = 32'h0000_0000;
    for (int k = 1; k <= 15; k++) begin
      tick();
      if (k == 5) rs1 = 32'h5353_0001;
      if (k == 10) valid_a[0] = 1'b0;
      if (ready_a[0] === 1'b1) strobes++;
      checks++;
      if (ready_a[0] !== (k == 4 || k == 9 || k == 14)) begin
        errors++;
        $display("FAIL b2b_ready cycle %0d got %b", k, ready_a[0]);
      end
      if (k == 4 || k == 9 || k == 14) begin
        want = (k == 4) ? 32'h637c_777b : (k == 9) ? 32'h6363_6363 : 32'heded_637c;
        checks++;
        if (rd_a[0] !== want) begin
          errors++;
          $display("FAIL b2b_rd cycle %0d got %h want %h", k, rd_a[0], want);
        end
      end
    end
    checks++;
    if (strobes != 3) begin
      errors++;
      $display("FAIL b2b_strobe_count got %0d want 3", strobes);
    end
  endtask

  task automatic test_async_reset();
    dec = 1'b0; bmode = 1'b0; rs1 = 32'h0001_0203; valid_a[0] = 1'b1;
    tick();
    valid_a[0] = 1'b0;
    tick(); tick(); tick();
    #2 g_resetn = 1'b0;
    #1;
    checks++;
    if (busy_a[0] !== 1'b0 || ready_a[0] !== 1'b0 || rd_a[0] !== 32'h0) begin
      errors++;
      $display("FAIL async_reset busy=%b ready=%b rd=%h want 0 0 00000000",
               busy_a[0], ready_a[0], rd_a[0]);
    end
    tick();
    g_resetn = 1'b1;
    tick();
    rs1 = 32'h0001_0203; valid_a[0] = 1'b1;
    tick();
    valid_a[0] = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      checks++;
      if (ready_a[0] !== (k == 4)) begin
        errors++;
        $display("FAIL post_reset_ready cycle %0d got %b want %b", k, ready_a[0], (k == 4));
      end
    end
    checks++;
    if (rd_a[0] !== 32'h637c_777b) begin
      errors++;
      $display("FAIL post_reset_rd got %h want 637c777b", rd_a[0]);
    end
    tick();
  endtask

  initial begin
    for (int d = 0; d < 3; d++) valid_a[d] = 1'b0;
    test_reset();
    test_word_fwd();
    test_capture();
    test_multi();
    test_byte();
    test_back_to_back();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
